// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single TX FIFO write port among NUM_REQ byte producers.
// Grants one requester at a time in round-robin order and holds the grant
// for one packet or up to MAX_BURST bytes, whichever ends first. Writes are
// throttled on FIFO occupancy so bytes are never dropped or duplicated.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   req_valid       per-requester byte valid
//   req_data        per-requester byte, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last        per-requester end-of-packet marker
//   req_ready       per-requester accept (valid & ready = byte taken)
//   fifo_w_enable   TX FIFO write strobe
//   fifo_w_data     TX FIFO write byte
//   fifo_count      TX FIFO occupancy, 0..DEPTH (larger values read as full)
//   fifo_r_enable   TX FIFO popped this cycle
//   grant_id        current / last granted requester
//   busy            high while a grant is held
//
// state   | meaning
// S_IDLE  | no grant; pick next requester round-robin, no transfer
// S_BURST | grant held; move bytes from granted requester while FIFO has space

module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_w_enable,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   input  logic [ADDR_WIDTH:0]           fifo_count,
   input  logic                          fifo_r_enable,
   output logic [IDW-1:0]                grant_id,
   output logic                          busy
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [CW-1:0]       CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  grant_q, grant_d;
   logic [IDW-1:0]  last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  pick_found;
   logic [IDW-1:0]        pick_id;
   logic                  space;
   logic                  xfer;

   // Mux out the granted requester's signals.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == IDW'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Scan last+1, last+2, ... so the previous winner has lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = last_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!pick_found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_id    = IDW'((int'(last_q) + k) % NUM_REQ);
         end
      end
   end

   // A full FIFO still accepts a byte when it is popped in the same cycle.
   assign space = (fifo_count < DEPTH) | ((fifo_count == DEPTH) & fifo_r_enable);
   assign xfer  = (state_q == S_BURST) & sel_valid & space;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      req_ready     = '0;
      fifo_w_enable = 1'b0;
      fifo_w_data   = '0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = pick_id;
               cnt_d   = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = space & (grant_q == IDW'(i));
            end
            if (xfer) begin
               fifo_w_enable = 1'b1;
               fifo_w_data   = sel_data;
               cnt_d         = cnt_q + 1'b1;
               if (sel_last || (cnt_q == CNT_LAST)) begin
                  state_d = S_IDLE;
                  last_d  = grant_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == S_BURST);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 8-bit bytes, depth 256,
// burst 16). Inputs change on the falling edge; outputs are checked 1 ns later.

module tb_uart_tx_arbiter;

   logic        CLK;
   logic        RST;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_w_enable;
   logic [7:0]  fifo_w_data;
   logic [8:0]  fifo_count;
   logic        fifo_r_enable;
   logic [1:0]  grant_id;
   logic        busy;

   int n_chk;
   int n_bad;
   int pos [4];
   int k1, k3, ph, g, b;

   uart_tx_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(16)
   ) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready),
      .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data),
      .fifo_count(fifo_count), .fifo_r_enable(fifo_r_enable),
      .grant_id(grant_id), .busy(busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_inputs();
      req_valid     = '0;
      req_data      = '0;
      req_last      = '0;
      fifo_count    = '0;
      fifo_r_enable = 1'b0;
   endtask

   // Leaves the bench on a falling edge with RST just released.
   task automatic do_reset();
      RST = 1'b1;
      clr_inputs();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;

      // ---- reset values
      do_reset();
      #1;
      chk_val("rst_busy", busy, 0);
      chk_val("rst_wen", fifo_w_enable, 0);
      chk_val("rst_wdata", fifo_w_data, 0);
      chk_val("rst_gnt", grant_id, 0);
      chk_val("rst_ready", req_ready, 0);
      @(negedge CLK);

      // ---- single requester 2, bytes 41 42 43
      req_valid = 4'b0100; req_data[23:16] = 8'h41; req_last = 4'b0000;
      #1;
      chk_val("t1_idle_wen", fifo_w_enable, 0);
      chk_val("t1_idle_busy", busy, 0);
      @(negedge CLK);
      #1;
      chk_val("t1_gnt", grant_id, 2);
      chk_val("t1_busy", busy, 1);
      chk_val("t1_ready", req_ready, 4'b0100);
      chk_val("t1_wen0", fifo_w_enable, 1);
      chk_val("t1_data0", fifo_w_data, 8'h41);
      @(negedge CLK);
      req_data[23:16] = 8'h42;
      #1;
      chk_val("t1_wen1", fifo_w_enable, 1);
      chk_val("t1_data1", fifo_w_data, 8'h42);
      @(negedge CLK);
      req_data[23:16] = 8'h43; req_last = 4'b0100;
      #1;
      chk_val("t1_wen2", fifo_w_enable, 1);
      chk_val("t1_data2", fifo_w_data, 8'h43);
      @(negedge CLK);
      clr_inputs();
      #1;
      chk_val("t1_done_busy", busy, 0);
      chk_val("t1_done_wen", fifo_w_enable, 0);

      // ---- all four valid, 2-byte packets: grants 0,1,2,3,0 with idle gaps
      do_reset();
      for (int i = 0; i < 4; i++) pos[i] = 0;
      for (int c = 0; c < 15; c++) begin
         req_valid = 4'hF;
         for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = 8'(16*i + pos[i]);
            req_last[i]        = (pos[i] == 1);
         end
         #1;
         ph = c % 3;
         g  = (c / 3) % 4;
         chk_val("rr_wen", fifo_w_enable, (ph != 0));
         if (ph != 0) begin
            chk_val("rr_gnt", grant_id, g);
            chk_val("rr_data", fifo_w_data, 16*g + ph - 1);
         end
         for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) pos[i] = (pos[i] + 1) % 2;
         @(negedge CLK);
      end

      // ---- requesters 1 and 3 stream 40-byte packets, bursts capped at 16
      do_reset();
      k1 = 0; k3 = 0;
      for (int c = 0; c < 51; c++) begin
         req_valid       = 4'b1010;
         req_data[15:8]  = 8'(k1);
         req_data[31:24] = 8'(8'h80 + k3);
         req_last        = {(k3 == 39), 1'b0, (k1 == 39), 1'b0};
         #1;
         ph = c % 17;
         b  = c / 17;
         chk_val("mb_wen", fifo_w_enable, (ph != 0));
         if (ph != 0) begin
            chk_val("mb_gnt", grant_id, (b % 2 == 0) ? 1 : 3);
            chk_val("mb_data", fifo_w_data,
                    ((b % 2 == 0) ? 0 : 8'h80) + (b / 2) * 16 + ph - 1);
         end
         if (req_ready[1]) k1++;
         if (req_ready[3]) k3++;
         @(negedge CLK);
      end
      chk_val("mb_k1", k1, 32);
      chk_val("mb_k3", k3, 16);

      // ---- full FIFO, then full with simultaneous pop
      do_reset();
      req_valid = 4'b0001; req_data[7:0] = 8'h5A; req_last = 4'b0001;
      fifo_count = 9'd256;
      #1;
      chk_val("ff_idle_wen", fifo_w_enable, 0);
      @(negedge CLK);
      #1;
      chk_val("ff_busy", busy, 1);
      chk_val("ff_ready", req_ready, 0);
      chk_val("ff_wen", fifo_w_enable, 0);
      @(negedge CLK);
      fifo_count = 9'd300;
      #1;
      chk_val("ff_over_ready", req_ready, 0);
      chk_val("ff_over_wen", fifo_w_enable, 0);
      @(negedge CLK);
      fifo_count = 9'd256; fifo_r_enable = 1'b1;
      #1;
      chk_val("ff_pop_ready", req_ready, 4'b0001);
      chk_val("ff_pop_wen", fifo_w_enable, 1);
      chk_val("ff_pop_data", fifo_w_data, 8'h5A);
      @(negedge CLK);
      clr_inputs();
      #1;
      chk_val("ff_done_busy", busy, 0);

      // ---- granted requester 0 stalls 5 cycles while requester 1 waits
      do_reset();
      req_valid = 4'b0011; req_data[7:0] = 8'hA0; req_data[15:8] = 8'hB0;
      req_last = 4'b0010;
      #1;
      chk_val("st_idle_wen", fifo_w_enable, 0);
      @(negedge CLK);
      #1;
      chk_val("st_gnt0", grant_id, 0);
      chk_val("st_data0", fifo_w_data, 8'hA0);
      @(negedge CLK);
      for (int c = 0; c < 5; c++) begin
         req_valid = 4'b0010;
         #1;
         chk_val("st_hold_wen", fifo_w_enable, 0);
         chk_val("st_hold_gnt", grant_id, 0);
         chk_val("st_hold_ready", req_ready, 4'b0001);
         @(negedge CLK);
      end
      req_valid = 4'b0011; req_data[7:0] = 8'hA1;
      #1;
      chk_val("st_data1", fifo_w_data, 8'hA1);
      chk_val("st_wen1", fifo_w_enable, 1);
      @(negedge CLK);
      req_data[7:0] = 8'hA2; req_last = 4'b0011;
      #1;
      chk_val("st_data2", fifo_w_data, 8'hA2);
      @(negedge CLK);
      req_valid = 4'b0010;
      #1;
      chk_val("st_gap_wen", fifo_w_enable, 0);
      chk_val("st_gap_busy", busy, 0);
      @(negedge CLK);
      #1;
      chk_val("st_gnt1", grant_id, 1);
      chk_val("st_data_b", fifo_w_data, 8'hB0);
      @(negedge CLK);
      clr_inputs();

      // ---- reset during third byte of a requester-2 burst
      do_reset();
      req_valid = 4'b0100; req_data[23:16] = 8'hC0;
      #1;
      @(negedge CLK);
      #1;
      chk_val("rb_data0", fifo_w_data, 8'hC0);
      @(negedge CLK);
      req_data[23:16] = 8'hC1;
      #1;
      chk_val("rb_data1", fifo_w_data, 8'hC1);
      @(negedge CLK);
      req_data[23:16] = 8'hC2;
      #1;
      chk_val("rb_data2", fifo_w_data, 8'hC2);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      req_valid = 4'b0111; req_data[7:0] = 8'hD0; req_data[15:8] = 8'hE0;
      #1;
      chk_val("rb_busy", busy, 0);
      chk_val("rb_wen", fifo_w_enable, 0);
      chk_val("rb_gnt", grant_id, 0);
      chk_val("rb_ready", req_ready, 0);
      @(negedge CLK);
      #1;
      chk_val("rb_win_gnt", grant_id, 0);
      chk_val("rb_win_data", fifo_w_data, 8'hD0);
      @(negedge CLK);
      clr_inputs();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit FIFO write port among several byte producers (RAM dump, status reporter, debug echo, ...). It sits in front of the TX FIFO that feeds the UART transmitter, grants one requester at a time for a packet or bounded burst, and throttles writes on FIFO occupancy so no byte is lost or duplicated.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width
- ADDR_WIDTH, 8, TX FIFO address width; FIFO depth DEPTH = 2**ADDR_WIDTH
- MAX_BURST, 16, max bytes per grant (>=1)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has byte on its data slice
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte of requester i is last of its packet
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle when valid&ready
- fifo_w_enable  out  1  write strobe to TX FIFO
- fifo_w_data  out  DATA_WIDTH  byte to TX FIFO
- fifo_count  in  ADDR_WIDTH+1  TX FIFO occupancy, 0..DEPTH
- fifo_r_enable  in  1  TX FIFO being read this cycle (UART TX pop)
- grant_id  out  clog2(NUM_REQ)  currently/last granted requester
- busy  out  1  high in BURST state

## Operation
- Clock is CLK; reset is RST, synchronous and active-high.
- States: IDLE, BURST.
- IDLE: if any req_valid, select first valid index scanning last_grant+1, +2, ... modulo NUM_REQ; register grant_id, clear burst_cnt, go BURST. No transfer in IDLE.
- BURST: space = (fifo_count < DEPTH) | (fifo_count == DEPTH & fifo_r_enable). req_ready[grant_id] = space; all other req_ready = 0.
- Transfer when req_valid[grant_id] & space: fifo_w_enable = 1, fifo_w_data = granted slice (combinational pass-through), burst_cnt += 1.
- Exit BURST to IDLE on a transfer with req_last[grant_id] = 1, or on the transfer where burst_cnt reaches MAX_BURST-1 (MAX_BURST-th byte). Update last_grant = grant_id on exit.
- Granted requester dropping req_valid mid-packet: grant held, no timeout; no other requester served.
- fifo_w_enable never high outside BURST; never high when space = 0.
- burst_cnt width clog2(MAX_BURST+1); never wraps.
- fifo_count is trusted; values > DEPTH treated as full.

## Timing
- Reset values: state IDLE, grant_id 0, last_grant NUM_REQ-1 (requester 0 first priority), burst_cnt 0, busy 0, req_ready all 0, fifo_w_enable 0, fifo_w_data 0 when not writing.
- Arbitration latency: req_valid asserted in IDLE at cycle n -> busy, grant at n+1 -> first write at n+1 if space.
- Back-to-back: one byte per cycle within a burst; exactly one dead IDLE cycle between bursts.
- Full FIFO with simultaneous pop: write permitted same cycle (count stays DEPTH).
- Requester raising valid while another is granted waits; served in round-robin order after current burst ends.
- RST mid-burst: next cycle IDLE, all outputs at reset values; partial packet is not resumed.

## Test plan
- Single requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), FIFO empty -> grant_id 2 one cycle after valid, three consecutive fifo_w_enable cycles with those bytes, busy falls after 0x43.
- All 4 valid continuously, each packet 2 bytes -> grant order 0,1,2,3,0; 2 writes per grant, one idle cycle between grants.
- Requester 1 streams 40-byte packet, MAX_BURST 16, requester 3 also valid -> 16 bytes from 1, then 16 from 3... grants alternate 1,3,1 with no byte loss.
- fifo_count = 256 (DEPTH), fifo_r_enable = 0 -> req_ready 0, no write; set fifo_r_enable = 1 -> one write with count held 256.
- Granted requester 0 drops valid for 5 cycles mid-packet while requester 1 valid -> grant stays 0, no writes, resumes on valid; requester 1 served after req_last.
- RST asserted during 3rd byte of burst -> next cycle busy 0, fifo_w_enable 0, grant_id 0; afterwards requester 0 wins first arbitration.
